// File: rtl/beta_rf_stage_sb.sv
// Beta register-fetch stage: latches pc/ir, decodes operands and branch select,
// and stalls on load-use hazards tracked by a small destination-tag scoreboard.
module beta_rf_stage_sb #(
    parameter int unsigned       DATA_W    = 32,
    parameter logic [DATA_W-1:0] RESET_PC  = '0,
    parameter logic [31:0]       NOP_INSTR = 32'h83FF_FFFF,
    parameter logic [31:0]       BNE_INSTR = 32'h7BDF_FFFF,
    parameter int unsigned       SB_DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic [1:0]        irsrc,
    input  logic [DATA_W-1:0] pcin,
    input  logic [31:0]       irin,
    output logic [4:0]        ra1,
    output logic [4:0]        ra2,
    input  logic [DATA_W-1:0] rd1,
    input  logic [DATA_W-1:0] rd2,
    output logic [DATA_W-1:0] pcout,
    output logic [31:0]       irout,
    output logic [DATA_W-1:0] c_rel_a,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] jt,
    output logic [1:0]        pcsel,
    output logic [6:0]        bypass_addr,
    output logic              hz_stall,
    output logic              halt
);

    localparam logic [5:0] OP_LD  = 6'b011000;
    localparam logic [5:0] OP_ST  = 6'b011001;
    localparam logic [5:0] OP_JMP = 6'b011011;
    localparam logic [5:0] OP_BEQ = 6'b011100;
    localparam logic [5:0] OP_BNE = 6'b011101;
    localparam logic [5:0] OP_LDR = 6'b011111;
    localparam logic [4:0] R31    = 5'd31;

    logic [DATA_W-1:0] pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic              halt_q, halt_d;
    logic [4:0]        sb_q [SB_DEPTH];
    logic [4:0]        sb_d [SB_DEPTH];

    logic [5:0]        op;
    logic [5:0]        eop;
    logic [DATA_W-1:0] lit_sxt;
    logic [31:0]       ir_sel;
    logic              sb_hit;
    logic [1:0]        pcsel_raw;

    assign op      = ir_q[31:26];
    assign lit_sxt = {{(DATA_W-16){ir_q[15]}}, ir_q[15:0]};

    // Register-file read addresses
    always_comb begin
        ra1 = (op == OP_LDR) ? R31 : ir_q[20:16];
        if (op == OP_ST)
            ra2 = ir_q[25:21];
        else if (op[5:4] != 2'b10)
            ra2 = R31;
        else
            ra2 = ir_q[15:11];
    end

    // Any live (non-R31) scoreboard tag read by the current instruction
    always_comb begin
        sb_hit = 1'b0;
        for (int i = 0; i < int'(SB_DEPTH); i++) begin
            if (sb_q[i] != R31 && (sb_q[i] == ra1 || sb_q[i] == ra2))
                sb_hit = 1'b1;
        end
    end

    assign hz_stall = !stall && sb_hit;

    assign pcout   = pc_q;
    assign irout   = hz_stall ? NOP_INSTR : ir_q;
    assign c_rel_a = pc_q + (lit_sxt << 2);
    assign a       = (op == OP_LDR) ? c_rel_a : rd1;
    assign b       = (op[5:4] == 2'b10) ? rd2 : lit_sxt;
    assign d       = rd2;
    assign jt      = rd1;
    assign halt    = halt_q;

    // Bypass tag follows the word actually sent downstream (bubble while stalling)
    assign eop         = irout[31:26];
    assign bypass_addr = {(eop == OP_JMP || eop == OP_BEQ || eop == OP_BNE),
                          irout[31],
                          (eop == OP_ST) ? R31 : irout[25:21]};

    always_comb begin
        pcsel_raw = 2'd3;
        if (ir_q == 32'd0) begin
            pcsel_raw = 2'd0;
        end else if (op[5]) begin
            pcsel_raw = (op[3:1] == 3'b001 || op[2:0] == 3'b111) ? 2'd3 : 2'd0;
        end else begin
            case (op)
                OP_LD, OP_ST, OP_LDR: pcsel_raw = 2'd0;
                OP_JMP:               pcsel_raw = 2'd2;
                OP_BEQ:               pcsel_raw = (rd1 == '0) ? 2'd1 : 2'd0;
                OP_BNE:               pcsel_raw = (rd1 != '0) ? 2'd1 : 2'd0;
                default:              pcsel_raw = 2'd3;
            endcase
        end
    end

    assign pcsel = hz_stall ? 2'd0 : pcsel_raw;

    always_comb begin
        case (irsrc)
            2'd0:    ir_sel = irin;
            2'd1:    ir_sel = BNE_INSTR;
            default: ir_sel = NOP_INSTR;
        endcase
    end

    // Next state: stall freezes everything, halt freezes pc/ir/scoreboard
    always_comb begin
        pc_d   = pc_q;
        ir_d   = ir_q;
        halt_d = halt_q;
        sb_d   = sb_q;
        if (!stall && !halt_q) begin
            sb_d[0] = (!hz_stall && (op == OP_LD || op == OP_LDR)) ? ir_q[25:21] : R31;
            for (int i = 1; i < int'(SB_DEPTH); i++)
                sb_d[i] = sb_q[i-1];
            if (!hz_stall) begin
                pc_d   = pcin;
                ir_d   = ir_sel;
                halt_d = (ir_sel == 32'd0);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q   <= RESET_PC;
            ir_q   <= NOP_INSTR;
            halt_q <= 1'b0;
            for (int i = 0; i < int'(SB_DEPTH); i++)
                sb_q[i] <= R31;
        end else begin
            pc_q   <= pc_d;
            ir_q   <= ir_d;
            halt_q <= halt_d;
            sb_q   <= sb_d;
        end
    end

endmodule

// File: tb/tb_beta_rf_stage_sb.sv
// Directed bench for beta_rf_stage_sb (DATA_W=64, SB_DEPTH=2) with a per-cycle
// reference model keyed on register ready times rather than a tag pipeline.
module tb_beta_rf_stage_sb;

    localparam int unsigned DW  = 64;
    localparam int unsigned SBD = 2;
    localparam logic [31:0] NOP  = 32'h83FF_FFFF;
    localparam logic [31:0] BNEW = 32'h7BDF_FFFF;

    localparam logic [31:0] LD3    = {6'b011000, 5'd3, 5'd31, 16'd0};
    localparam logic [31:0] LD7    = {6'b011000, 5'd7, 5'd31, 16'd0};
    localparam logic [31:0] ADD435 = {6'b100000, 5'd4, 5'd3, 5'd5, 11'd0};
    localparam logic [31:0] ADD612 = {6'b100000, 5'd6, 5'd1, 5'd2, 11'd0};
    localparam logic [31:0] ADD412 = {6'b100000, 5'd4, 5'd1, 5'd2, 11'd0};
    localparam logic [31:0] ADD877 = {6'b100000, 5'd8, 5'd7, 5'd7, 11'd0};
    localparam logic [31:0] BEQ    = {6'b011100, 5'd1, 5'd2, 16'd5};
    localparam logic [31:0] BNE    = {6'b011101, 5'd1, 5'd2, 16'd5};
    localparam logic [31:0] JMP    = {6'b011011, 5'd0, 5'd1, 16'd0};
    localparam logic [31:0] ILL    = {6'b000101, 5'd1, 5'd2, 16'd0};
    localparam logic [31:0] ALUILL = {6'b100010, 5'd1, 5'd2, 5'd3, 11'd0};
    localparam logic [31:0] LDR9   = {6'b011111, 5'd9, 5'd0, 16'hFFFF};
    localparam logic [31:0] BEQW   = {6'b011100, 5'd31, 5'd31, 16'd2};
    localparam logic [31:0] ST9    = {6'b011001, 5'd9, 5'd31, 16'd0};

    logic          clk = 1'b0, reset = 1'b0, stall = 1'b0;
    logic [1:0]    irsrc = 2'd0;
    logic [DW-1:0] pcin = '0, rd1 = '0, rd2 = '0;
    logic [31:0]   irin = NOP;
    logic [4:0]    ra1, ra2;
    logic [DW-1:0] pcout, c_rel_a, a, b, d, jt;
    logic [31:0]   irout;
    logic [1:0]    pcsel;
    logic [6:0]    bypass_addr;
    logic          hz_stall, halt;

    beta_rf_stage_sb #(
        .DATA_W(DW), .RESET_PC(64'd0), .NOP_INSTR(NOP), .BNE_INSTR(BNEW), .SB_DEPTH(SBD)
    ) dut (
        .clk(clk), .reset(reset), .stall(stall), .irsrc(irsrc), .pcin(pcin), .irin(irin),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2), .pcout(pcout), .irout(irout),
        .c_rel_a(c_rel_a), .a(a), .b(b), .d(d), .jt(jt), .pcsel(pcsel),
        .bypass_addr(bypass_addr), .hz_stall(hz_stall), .halt(halt)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: a loaded register is busy until ready[r] shift-cycles have elapsed
    logic [DW-1:0] m_pc = '0;
    logic [31:0]   m_ir = NOP;
    logic          m_halt = 1'b0;
    int            m_cnt = 0;
    int            m_ready [32];
    logic          mh;
    logic [31:0]   nir;

    function automatic logic [4:0] m_ra1(input logic [31:0] w);
        return (w[31:26] == 6'b011111) ? 5'd31 : w[20:16];
    endfunction

    function automatic logic [4:0] m_ra2(input logic [31:0] w);
        if (w[31:26] == 6'b011001) return w[25:21];
        if (w[31:30] != 2'b10) return 5'd31;
        return w[15:11];
    endfunction

    function automatic logic m_busy(input logic [4:0] r);
        return (r != 5'd31) && (m_cnt < m_ready[r]);
    endfunction

    function automatic logic m_haz();
        return m_busy(m_ra1(m_ir)) || m_busy(m_ra2(m_ir));
    endfunction

    function automatic logic [1:0] m_pcsel(input logic [31:0] w, input logic [63:0] r1);
        logic [5:0] o;
        o = w[31:26];
        if (w == 32'd0) return 2'd0;
        if (o[5]) return (o[3:1] == 3'b001 || o[2:0] == 3'b111) ? 2'd3 : 2'd0;
        case (o)
            6'b011000, 6'b011001, 6'b011111: return 2'd0;
            6'b011011: return 2'd2;
            6'b011100: return (r1 == 64'd0) ? 2'd1 : 2'd0;
            6'b011101: return (r1 != 64'd0) ? 2'd1 : 2'd0;
            default:   return 2'd3;
        endcase
    endfunction

    task automatic m_rst();
        m_pc = '0; m_ir = NOP; m_halt = 1'b0; m_cnt = 0;
        for (int r = 0; r < 32; r++) m_ready[r] = 0;
    endtask

    initial begin
        m_rst();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_rst();
            end else if (!stall && !m_halt) begin
                mh = m_haz();
                m_cnt++;
                if (!mh) begin
                    if (m_ir[31:26] == 6'b011000 || m_ir[31:26] == 6'b011111)
                        m_ready[m_ir[25:21]] = m_cnt + int'(SBD);
                    nir = (irsrc == 2'd0) ? irin : (irsrc == 2'd1) ? BNEW : NOP;
                    m_pc = pcin;
                    m_ir = nir;
                    if (nir == 32'd0) m_halt = 1'b1;
                end
            end
        end
    end

    task automatic compare_all();
        logic          h;
        logic [31:0]   eir;
        logic [5:0]    o, eo;
        logic [63:0]   sx, crel;
        h    = !stall && m_haz();
        eir  = h ? NOP : m_ir;
        o    = m_ir[31:26];
        eo   = eir[31:26];
        sx   = {{48{m_ir[15]}}, m_ir[15:0]};
        crel = m_pc + sx * 64'd4;
        chk("pcout", pcout, m_pc);
        chk("irout", irout, eir);
        chk("hz_stall", hz_stall, h);
        chk("halt", halt, m_halt);
        chk("ra1", ra1, m_ra1(m_ir));
        chk("ra2", ra2, m_ra2(m_ir));
        chk("c_rel_a", c_rel_a, crel);
        chk("a", a, (o == 6'b011111) ? crel : rd1);
        chk("b", b, (o[5:4] == 2'b10) ? rd2 : sx);
        chk("d", d, rd2);
        chk("jt", jt, rd1);
        chk("pcsel", pcsel, h ? 2'd0 : m_pcsel(m_ir, rd1));
        chk("bypass_addr", bypass_addr,
            {57'd0, (eo == 6'b011011 || eo == 6'b011100 || eo == 6'b011101), eir[31],
             (eo == 6'b011001) ? 5'd31 : eir[25:21]});
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) compare_all();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [31:0] w, input logic [63:0] pc);
        irin = w; pcin = pc; irsrc = 2'd0;
        tick();
    endtask

    // Called just after a rising edge: reset arrives mid-cycle and must act at once
    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        chk("rst_pcout", pcout, 64'd0);
        chk("rst_irout", irout, NOP);
        chk("rst_pcsel", pcsel, 2'd0);
        chk("rst_halt", halt, 1'b0);
        chk("rst_hz", hz_stall, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        chk_en = 1'b1;
        rd1 = 64'h11; rd2 = 64'h22;

        feed(ADD612, 64'h40);
        do_reset();

        // Load-use: two bubble cycles, ADD leaves on the third
        feed(LD3, 64'd4);
        feed(ADD435, 64'd8);
        @(negedge clk);
        chk("lu_hz1", hz_stall, 1'b1);
        chk("lu_irout1", irout, NOP);
        chk("lu_pcsel1", pcsel, 2'd0);
        chk("lu_bypass1", bypass_addr, 7'h3F);
        feed(ADD612, 64'd12);
        @(negedge clk);
        chk("lu_hz2", hz_stall, 1'b1);
        chk("lu_pc2", pcout, 64'd8);
        tick();
        @(negedge clk);
        chk("lu_hz3", hz_stall, 1'b0);
        chk("lu_irout3", irout, ADD435);
        tick();
        @(negedge clk);
        chk("lu_next", irout, ADD612);
        chk("lu_next_pc", pcout, 64'd12);

        // Non-conflicting consumer after a load
        feed(LD3, 64'd16);
        feed(ADD412, 64'd20);
        @(negedge clk);
        chk("nc_hz", hz_stall, 1'b0);
        chk("nc_irout", irout, ADD412);

        // Branch / jump / illegal decode
        feed(BEQ, 64'd24); rd1 = 64'd0;
        @(negedge clk);
        chk("beq_taken", pcsel, 2'd1);
        chk("beq_bypass", bypass_addr, 7'h41);
        feed(BNE, 64'd28); rd1 = 64'd5;
        @(negedge clk);
        chk("bne_taken", pcsel, 2'd1);
        feed(BNE, 64'd32); rd1 = 64'd0;
        @(negedge clk);
        chk("bne_not", pcsel, 2'd0);
        feed(JMP, 64'd36); rd1 = 64'h1234;
        @(negedge clk);
        chk("jmp_pcsel", pcsel, 2'd2);
        chk("jmp_jt", jt, 64'h1234);
        feed(ILL, 64'd40);
        @(negedge clk);
        chk("ill_pcsel", pcsel, 2'd3);
        feed(ALUILL, 64'd44);
        @(negedge clk);
        chk("aluill_pcsel", pcsel, 2'd3);

        // LDR relative address, 64-bit wrap, ST reading a just-loaded register
        feed(LDR9, 64'd100);
        @(negedge clk);
        chk("ldr_crel", c_rel_a, 64'd96);
        chk("ldr_a", a, 64'd96);
        chk("ldr_ra1", ra1, 5'd31);
        feed(BEQW, 64'hFFFF_FFFF_FFFF_FFFC);
        @(negedge clk);
        chk("wrap_crel", c_rel_a, 64'd4);
        chk("wrap_b", b, 64'd2);
        feed(ST9, 64'd108);
        @(negedge clk);
        chk("st_hz", hz_stall, 1'b1);
        chk("st_ra2", ra2, 5'd9);
        tick();
        @(negedge clk);
        chk("st_hz_clear", hz_stall, 1'b0);
        chk("st_bypass", bypass_addr, 7'h1F);

        // External stall masks a pending hazard and freezes state
        feed(LD7, 64'd200);
        feed(ADD877, 64'd204);
        stall = 1'b1;
        irin = ADD612; pcin = 64'd999;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stl_hz", hz_stall, 1'b0);
            chk("stl_pc", pcout, 64'd204);
            chk("stl_ir", irout, ADD877);
            tick();
        end
        stall = 1'b0;
        @(negedge clk);
        chk("stl_resume1", hz_stall, 1'b1);
        tick();
        @(negedge clk);
        chk("stl_resume2", hz_stall, 1'b1);
        tick();
        @(negedge clk);
        chk("stl_resume3", hz_stall, 1'b0);
        tick();
        @(negedge clk);
        chk("stl_after_pc", pcout, 64'd999);

        // irsrc injection
        irsrc = 2'd1; pcin = 64'd300;
        tick();
        @(negedge clk);
        chk("irsrc1", irout, BNEW);
        irsrc = 2'd2; irin = ADD612;
        tick();
        @(negedge clk);
        chk("irsrc2", irout, NOP);
        irsrc = 2'd3;
        tick();
        @(negedge clk);
        chk("irsrc3", irout, NOP);
        irsrc = 2'd0;

        // Reset in the middle of a hazard flushes the scoreboard
        feed(LD3, 64'd320);
        feed(ADD435, 64'd324);
        @(negedge clk);
        chk("rmh_hz", hz_stall, 1'b1);
        tick();
        do_reset();
        feed(ADD435, 64'd328);
        @(negedge clk);
        chk("rmh_post_hz", hz_stall, 1'b0);
        chk("rmh_post_ir", irout, ADD435);

        // Halt: ir==0 sticks until reset
        feed(32'd0, 64'd400);
        @(negedge clk);
        chk("halt_set", halt, 1'b1);
        chk("halt_pcsel", pcsel, 2'd0);
        feed(ADD612, 64'd404);
        feed(LD3, 64'd408);
        @(negedge clk);
        chk("halt_pc", pcout, 64'd400);
        chk("halt_ir", irout, 32'd0);
        do_reset();
        @(negedge clk);
        chk("halt_cleared", halt, 1'b0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
